// File: rtl/field_prog_pkg.sv
// Shared types and helpers for the field rule programmer.
package field_prog_pkg;

  // Control nibble that makes a field unit pass its header field through unchanged.
  localparam logic [3:0] LU_CTRL_PASS = 4'h0;

  // Width of a field-select index; never narrower than one bit.
  function automatic int fsel_w(input int num_fields);
    if (num_fields <= 2) return 1;
    return $clog2(num_fields);
  endfunction

  // Instruction word width: control nibble on top of the header-field operand.
  function automatic int inst_w(input int data_width);
    return data_width + 4;
  endfunction

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Ready is combinational; the priority
// pointer flips to the other requester after every grant and holds otherwise.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  output logic [1:0] o_ready,
  output logic       o_grant_idx,
  output logic       o_ptr
);

  logic r_ptr;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    o_ready[0] = i_valid[0] && (!i_valid[1] || (r_ptr == 1'b0));
    o_ready[1] = i_valid[1] && (!i_valid[0] || (r_ptr == 1'b1));
  end

  assign o_grant_idx = o_ready[1];
  assign o_ptr       = r_ptr;

  // Hand priority to the other requester after each accepted grant.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (|o_ready) begin
      r_ptr <= ~o_grant_idx;
    end
  end

endmodule

// File: rtl/field_rule_programmer.sv
// Write-side controller for a bank of field action units: sweeps every
// instruction-memory address with INIT_WORD, then issues one registered
// write per accepted rule request from two round-robin requesters.
module field_rule_programmer
  import field_prog_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    NUM_FIELDS = 3,
  parameter logic [DATA_WIDTH+3:0] INIT_WORD  = {LU_CTRL_PASS, {DATA_WIDTH{1'b0}}},
  localparam int                   FSW        = fsel_w(NUM_FIELDS),
  localparam int                   IW         = inst_w(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*FSW-1:0]        req_field,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*IW-1:0]         req_data,
  output logic [NUM_FIELDS-1:0]   we,
  output logic [ADDR_WIDTH-1:0]   w_addr,
  output logic [IW-1:0]           wd,
  output logic                    init_done,
  output logic                    err
);

  // One extra counter bit lets the sweep spend a cycle past the last address
  // before entering RUN, so init_done rises after the final sweep write.
  localparam int             CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(1 << ADDR_WIDTH);

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [NUM_FIELDS-1:0]   r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0]   r_w_addr, w_addr_nxt;
  logic [IW-1:0]           r_wd, w_wd_nxt;
  logic                    r_init_done;
  logic                    r_err, w_err_nxt;

  logic [1:0]              w_arb_valid;
  logic [1:0]              w_arb_ready;
  logic                    w_grant_idx;
  logic                    w_unused_ptr;
  logic [FSW-1:0]          w_sel_field;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [IW-1:0]           w_sel_data;

  // Requests are only visible to the arbiter in RUN and never while reset is held.
  assign w_arb_valid = ((r_state == ST_RUN) && !rst) ? req_valid : 2'b00;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (w_arb_valid),
    .o_ready     (w_arb_ready),
    .o_grant_idx (w_grant_idx),
    .o_ptr       (w_unused_ptr)
  );

  assign req_ready   = w_arb_ready;
  assign w_sel_field = w_grant_idx ? req_field[FSW +: FSW]               : req_field[0 +: FSW];
  assign w_sel_addr  = w_grant_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : req_addr[0 +: ADDR_WIDTH];
  assign w_sel_data  = w_grant_idx ? req_data[IW +: IW]                  : req_data[0 +: IW];

  // Next-state and next-output decode for the sweep / run controller.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = '0;
    w_addr_nxt  = r_w_addr;
    w_wd_nxt    = r_wd;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == CNT_END) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_we_nxt   = '1;
          w_addr_nxt = r_cnt[ADDR_WIDTH-1:0];
          w_wd_nxt   = INIT_WORD;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
        if (clear_req) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (|w_arb_ready) begin
          w_addr_nxt = w_sel_addr;
          w_wd_nxt   = w_sel_data;
          if (int'(w_sel_field) < NUM_FIELDS) begin
            w_we_nxt = NUM_FIELDS'(1) << w_sel_field;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        // A write granted alongside clear_req still issues; the sweep follows it.
        if (clear_req) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State, sweep counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_we        <= '0;
      r_w_addr    <= '0;
      r_wd        <= '0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_w_addr    <= w_addr_nxt;
      r_wd        <= w_wd_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      r_err       <= w_err_nxt;
    end
  end

  assign we        = r_we;
  assign w_addr    = r_w_addr;
  assign wd        = r_wd;
  assign init_done = r_init_done;
  assign err       = r_err;

endmodule

// File: tb/tb_field_rule_programmer.sv
// Self-checking bench for field_rule_programmer (DATA_WIDTH=32, ADDR_WIDTH=2, NUM_FIELDS=3).
module tb_field_rule_programmer;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int NF  = 3;
  localparam int IW  = DW + 4;
  localparam int NV  = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_req;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [3:0]    req_field;
  logic [3:0]    req_addr;
  logic [71:0]   req_data;
  logic [2:0]    we;
  logic [1:0]    w_addr;
  logic [35:0]   wd;
  logic          init_done;
  logic          err;

  always #5 clk = ~clk;

  field_rule_programmer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_FIELDS (NF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_field (req_field),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .we        (we),
    .w_addr    (w_addr),
    .wd        (wd),
    .init_done (init_done),
    .err       (err)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  f0, a0;
    logic [35:0] d0;
    logic [1:0]  f1, a1;
    logic [35:0] d1;
    logic        clr;
    logic [1:0]  exp_ready;
    logic [2:0]  exp_we;
    logic [1:0]  exp_addr;
    logic [35:0] exp_wd;
    logic        exp_err;
    logic        exp_done;
    logic        chk_aw;
  } vec_t;

  typedef struct {
    logic [2:0]  we;
    logic [1:0]  addr;
    logic [35:0] wd;
    logic        err;
    logic        done;
    logic        chk_aw;
    int          row;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    string tag;
    tag = $sformatf("row%0d", e.row);
    check({tag, " we"},        64'(we),        64'(e.we));
    check({tag, " err"},       64'(err),       64'(e.err));
    check({tag, " init_done"}, 64'(init_done), 64'(e.done));
    if (e.chk_aw) begin
      check({tag, " w_addr"}, 64'(w_addr), 64'(e.addr));
      check({tag, " wd"},     64'(wd),     64'(e.wd));
    end
  endtask

  function automatic vec_t mkvec(
    input logic [1:0] v, input logic [1:0] f0, input logic [1:0] a0, input logic [35:0] d0,
    input logic [1:0] f1, input logic [1:0] a1, input logic [35:0] d1, input logic clr,
    input logic [1:0] rdy, input logic [2:0] ewe, input logic [1:0] ea, input logic [35:0] ewd,
    input logic eerr, input logic edone, input logic chk);
    vec_t r;
    r.valid = v;   r.f0 = f0; r.a0 = a0; r.d0 = d0;
    r.f1 = f1;     r.a1 = a1; r.d1 = d1; r.clr = clr;
    r.exp_ready = rdy; r.exp_we = ewe; r.exp_addr = ea; r.exp_wd = ewd;
    r.exp_err = eerr;  r.exp_done = edone; r.chk_aw = chk;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    req_valid = v.valid;
    req_field = {v.f1, v.f0};
    req_addr  = {v.a1, v.a0};
    req_data  = {v.d1, v.d0};
    clear_req = v.clr;
  endtask

  // Bound the whole run so a stuck design can never hang the bench.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;

    // Each row: inputs this cycle, expected ready this cycle, expected outputs next cycle.
    vecs[0]  = mkvec(2'b01, 2'd1, 2'd2, 36'h5_DEADBEEF, 2'd0, 2'd0, 36'h0,          1'b0, 2'b01, 3'b010, 2'd2, 36'h5_DEADBEEF, 1'b0, 1'b1, 1'b1);
    vecs[1]  = mkvec(2'b10, 2'd1, 2'd2, 36'h5_DEADBEEF, 2'd3, 2'd1, 36'h9_12345678, 1'b0, 2'b10, 3'b000, 2'd0, 36'h0,          1'b1, 1'b1, 1'b0);
    vecs[2]  = mkvec(2'b00, 2'd0, 2'd0, 36'h0,          2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b000, 2'd0, 36'h0,          1'b0, 1'b1, 1'b0);
    vecs[3]  = mkvec(2'b11, 2'd0, 2'd0, 36'h1_00000000, 2'd2, 2'd1, 36'h2_11111111, 1'b0, 2'b01, 3'b001, 2'd0, 36'h1_00000000, 1'b0, 1'b1, 1'b1);
    vecs[4]  = mkvec(2'b11, 2'd1, 2'd2, 36'h3_22222222, 2'd2, 2'd1, 36'h2_11111111, 1'b0, 2'b10, 3'b100, 2'd1, 36'h2_11111111, 1'b0, 1'b1, 1'b1);
    vecs[5]  = mkvec(2'b11, 2'd1, 2'd2, 36'h3_22222222, 2'd0, 2'd3, 36'h4_33333333, 1'b0, 2'b01, 3'b010, 2'd2, 36'h3_22222222, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mkvec(2'b10, 2'd0, 2'd0, 36'h0,          2'd0, 2'd3, 36'h4_33333333, 1'b0, 2'b10, 3'b001, 2'd3, 36'h4_33333333, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mkvec(2'b00, 2'd0, 2'd0, 36'h0,          2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b000, 2'd0, 36'h0,          1'b0, 1'b1, 1'b0);
    vecs[8]  = mkvec(2'b10, 2'd0, 2'd0, 36'h0,          2'd1, 2'd3, 36'hA_0000000A, 1'b0, 2'b10, 3'b010, 2'd3, 36'hA_0000000A, 1'b0, 1'b1, 1'b1);
    vecs[9]  = mkvec(2'b01, 2'd2, 2'd1, 36'hF_FFFFFFFF, 2'd0, 2'd0, 36'h0,          1'b0, 2'b01, 3'b100, 2'd1, 36'hF_FFFFFFFF, 1'b0, 1'b1, 1'b1);
    vecs[10] = mkvec(2'b00, 2'd0, 2'd0, 36'h0,          2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b000, 2'd0, 36'h0,          1'b0, 1'b1, 1'b0);
    // Grant coincident with clear_req: the write still lands, init_done drops.
    vecs[11] = mkvec(2'b01, 2'd0, 2'd3, 36'h7_77777777, 2'd0, 2'd0, 36'h0,          1'b1, 2'b01, 3'b001, 2'd3, 36'h7_77777777, 1'b0, 1'b0, 1'b1);
    // Pending request held through the re-sweep; accepted once RUN returns.
    vecs[12] = mkvec(2'b01, 2'd1, 2'd0, 36'h8_88888888, 2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b111, 2'd0, 36'h0,          1'b0, 1'b0, 1'b1);
    vecs[13] = mkvec(2'b01, 2'd1, 2'd0, 36'h8_88888888, 2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b111, 2'd1, 36'h0,          1'b0, 1'b0, 1'b1);
    vecs[14] = mkvec(2'b01, 2'd1, 2'd0, 36'h8_88888888, 2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b111, 2'd2, 36'h0,          1'b0, 1'b0, 1'b1);
    vecs[15] = mkvec(2'b01, 2'd1, 2'd0, 36'h8_88888888, 2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b111, 2'd3, 36'h0,          1'b0, 1'b0, 1'b1);
    vecs[16] = mkvec(2'b01, 2'd1, 2'd0, 36'h8_88888888, 2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b000, 2'd0, 36'h0,          1'b0, 1'b1, 1'b0);
    vecs[17] = mkvec(2'b01, 2'd1, 2'd0, 36'h8_88888888, 2'd0, 2'd0, 36'h0,          1'b0, 2'b01, 3'b010, 2'd0, 36'h8_88888888, 1'b0, 1'b1, 1'b1);
    vecs[18] = mkvec(2'b00, 2'd0, 2'd0, 36'h0,          2'd0, 2'd0, 36'h0,          1'b0, 2'b00, 3'b000, 2'd0, 36'h0,          1'b0, 1'b1, 1'b0);

    // Reset with requester 0 already presenting the first table request.
    rst = 1'b1;
    apply(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset we",        64'(we),        64'(0));
    check("reset w_addr",    64'(w_addr),    64'(0));
    check("reset wd",        64'(wd),        64'(0));
    check("reset init_done", 64'(init_done), 64'(0));
    check("reset err",       64'(err),       64'(0));
    check("reset req_ready", 64'(req_ready), 64'(0));

    // Release reset; the next four cycles are the power-on sweep.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sweep%0d we", k),        64'(we),        64'(3'b111));
      check($sformatf("sweep%0d w_addr", k),    64'(w_addr),    64'(k));
      check($sformatf("sweep%0d wd", k),        64'(wd),        64'(0));
      check($sformatf("sweep%0d init_done", k), 64'(init_done), 64'(0));
      check($sformatf("sweep%0d req_ready", k), 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    #1;

    // First RUN cycle: no write pending, init_done high.
    e.we = 3'b000; e.addr = 2'd0; e.wd = 36'h0; e.err = 1'b0; e.done = 1'b1; e.chk_aw = 1'b0; e.row = -1;
    sb.push_back(e);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        check($sformatf("row%0d scoreboard empty", i), 64'(1), 64'(0));
      end else begin
        check_out(sb.pop_front());
      end
      check($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      e.we = vecs[i].exp_we;   e.addr = vecs[i].exp_addr; e.wd = vecs[i].exp_wd;
      e.err = vecs[i].exp_err; e.done = vecs[i].exp_done; e.chk_aw = vecs[i].chk_aw; e.row = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end

    // Drain the last expectation while pulsing clear_req in RUN.
    req_valid = 2'b00;
    clear_req = 1'b1;
    @(negedge clk);
    while (sb.size() > 0) check_out(sb.pop_front());
    @(posedge clk);
    #1 clear_req = 1'b0;
    @(negedge clk);
    check("clr we",        64'(we),        64'(0));
    check("clr init_done", 64'(init_done), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("resweep%0d w_addr", k), 64'(w_addr), 64'(k));
      check($sformatf("resweep%0d we", k),     64'(we),     64'(3'b111));
    end

    // Reset lands while the sweep is at address 2.
    rst       = 1'b1;
    req_valid = 2'b01;
    req_field = 4'b0010;
    req_addr  = 4'b0001;
    req_data  = {36'h0, 36'hC_0FFEE000};
    @(posedge clk);
    @(negedge clk);
    check("midrst we",        64'(we),        64'(0));
    check("midrst init_done", 64'(init_done), 64'(0));
    check("midrst w_addr",    64'(w_addr),    64'(0));
    check("midrst req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rstsweep%0d w_addr", k),    64'(w_addr),    64'(k));
      check($sformatf("rstsweep%0d we", k),        64'(we),        64'(3'b111));
      check($sformatf("rstsweep%0d req_ready", k), 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    @(negedge clk);
    check("post-rst init_done", 64'(init_done), 64'(1));
    check("post-rst req_ready", 64'(req_ready), 64'(2'b01));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    check("post-rst we",     64'(we),     64'(3'b100));
    check("post-rst w_addr", 64'(w_addr), 64'(1));
    check("post-rst wd",     64'(wd),     64'(36'hC_0FFEE000));
    @(posedge clk);
    @(negedge clk);
    check("post-rst we idle", 64'(we), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
